// File: rtl/addr_gen_upd_dwu_pkg.sv
// Shared definitions for the weight-update address generator:
// default bus width, FSM state encodings and a counter-width helper.
package addr_gen_upd_dwu_pkg;

    localparam int ADDR_WIDTH_DEF = 12;
    localparam int DRAIN_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // A counter over n values needs at least one bit, even when n is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-latency shift register: q_o reproduces d_i exactly DEPTH cycles later.
module delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/addr_gen_upd_dwu.sv
// Address generator for the weight-update MAC: walks (c, j, t) over the weight
// matrix and schedules one write-back per weight after the MAC pipeline latency.
//
// state | meaning
// IDLE  | waiting for en to start a run
// RUN   | issuing read addresses; en low stalls the counters
// DRAIN | waiting DELAY cycles for the final write-back to leave the pipeline
// DONE  | one-cycle completion pulse, then back to IDLE
module addr_gen_upd_dwu
    import addr_gen_upd_dwu_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int TIMESTEP   = 7,
    parameter int NUM_CELL   = 8,
    parameter int NUM_INPUT  = 8,
    parameter int DELAY      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] o_addr_d,
    output logic [ADDR_WIDTH-1:0] o_addr_x,
    output logic [ADDR_WIDTH-1:0] o_addr_w_rd,
    output logic                  o_valid,
    output logic                  o_acc,
    output logic                  o_wr,
    output logic [ADDR_WIDTH-1:0] o_addr_w_wr,
    output logic                  o_done
);

    localparam int TW = cnt_width(TIMESTEP);
    localparam int JW = cnt_width(NUM_INPUT);
    localparam int CW = cnt_width(NUM_CELL);

    state_e             state_q, state_d;
    logic [TW-1:0]      t_q, t_d;
    logic [JW-1:0]      j_q, j_d;
    logic [CW-1:0]      c_q, c_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;

    logic t_max, j_max, c_max, issue, push;
    logic [ADDR_WIDTH-1:0] t_a, j_a, c_a, w_idx;
    logic [ADDR_WIDTH:0]   pipe_in, pipe_out;

    assign t_max = (t_q == TW'(TIMESTEP - 1));
    assign j_max = (j_q == JW'(NUM_INPUT - 1));
    assign c_max = (c_q == CW'(NUM_CELL - 1));
    assign issue = (state_q == ST_RUN) && en;
    assign push  = issue && t_max;

    assign t_a   = ADDR_WIDTH'(t_q);
    assign j_a   = ADDR_WIDTH'(j_q);
    assign c_a   = ADDR_WIDTH'(c_q);
    assign w_idx = c_a * ADDR_WIDTH'(NUM_INPUT) + j_a;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        j_d     = j_q;
        c_d     = c_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (en) begin
                    if (!t_max) begin
                        t_d = t_q + TW'(1);
                    end else begin
                        t_d = '0;
                        if (!j_max) begin
                            j_d = j_q + JW'(1);
                        end else begin
                            j_d = '0;
                            if (!c_max) begin
                                c_d = c_q + CW'(1);
                            end else begin
                                c_d     = '0;
                                drain_d = DRAIN_W'(DELAY - 1);
                                state_d = ST_DRAIN;
                            end
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) state_d = ST_DONE;
                else               drain_d = drain_q - DRAIN_W'(1);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            j_q     <= '0;
            c_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            j_q     <= j_d;
            c_q     <= c_d;
            drain_q <= drain_d;
        end
    end

    // Address is zeroed when not pushing so idle pipeline slots carry nothing.
    assign pipe_in = {push, push ? w_idx : '0};

    delay_line #(
        .WIDTH (ADDR_WIDTH + 1),
        .DEPTH (DELAY)
    ) u_wb_pipe (
        .clk (clk),
        .rst (rst),
        .d_i (pipe_in),
        .q_o (pipe_out)
    );

    assign o_wr        = pipe_out[ADDR_WIDTH];
    assign o_addr_w_wr = o_wr ? pipe_out[ADDR_WIDTH-1:0] : '0;
    assign o_done      = (state_q == ST_DONE);

    // Counters only move on issue, so addresses and o_acc hold through stalls.
    always_comb begin
        o_addr_d    = '0;
        o_addr_x    = '0;
        o_addr_w_rd = '0;
        o_valid     = 1'b0;
        o_acc       = 1'b0;
        if (state_q == ST_RUN) begin
            o_addr_d    = t_a * ADDR_WIDTH'(NUM_CELL) + c_a;
            o_addr_x    = t_a * ADDR_WIDTH'(NUM_INPUT) + j_a;
            o_addr_w_rd = w_idx;
            o_valid     = en;
            o_acc       = (t_q != '0);
        end
    end

endmodule

// File: tb/tb_addr_gen_upd_dwu.sv
// Directed bench for addr_gen_upd_dwu: default and small-parameter instances,
// full runs, a stall window, and an asynchronous reset mid-run.
module tb_addr_gen_upd_dwu;

    logic clk = 1'b0;
    logic rst;
    logic en0, en1;

    logic [11:0] d0, x0, wrd0, ww0;
    logic        v0, a0, w0, dn0;
    logic [11:0] d1, x1, wrd1, ww1;
    logic        v1, a1, w1, dn1;

    int checks = 0;
    int errors = 0;
    int cur_k  = 0;

    always #5 clk = ~clk;

    addr_gen_upd_dwu u_dut0 (
        .clk (clk), .rst (rst), .en (en0),
        .o_addr_d (d0), .o_addr_x (x0), .o_addr_w_rd (wrd0),
        .o_valid (v0), .o_acc (a0), .o_wr (w0),
        .o_addr_w_wr (ww0), .o_done (dn0)
    );

    addr_gen_upd_dwu #(
        .TIMESTEP (1), .NUM_CELL (2), .NUM_INPUT (3), .DELAY (1)
    ) u_dut1 (
        .clk (clk), .rst (rst), .en (en1),
        .o_addr_d (d1), .o_addr_x (x1), .o_addr_w_rd (wrd1),
        .o_valid (v1), .o_acc (a1), .o_wr (w1),
        .o_addr_w_wr (ww1), .o_done (dn1)
    );

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s k=%0d got %0d expected %0d", tag, cur_k, act, exp);
        end
    endtask

    // Runs one complete start..IDLE sequence on instance sel, with an optional
    // stall window of sl cycles starting at cycle sa, checking every cycle.
    task automatic run_seq(input int sel, input int T, input int C, input int I,
                           input int D, input int sa, input int sl);
        int n_issue, last_k, m, q, mq, t, j, c, wr_cnt;
        int sv, sd, sx, sw, sa_o, swr, sww, sdn;
        int e_wr, e_ww;
        bit stalled, in_run, en_val;
        n_issue = T * C * I;
        last_k  = n_issue + sl + D + 1;
        wr_cnt  = 0;
        if (sel == 0) en0 = 1'b1; else en1 = 1'b1;
        for (int k = 0; k <= last_k; k++) begin
            @(posedge clk);
            #1;
            cur_k   = k;
            stalled = (k >= sa) && (k < sa + sl);
            en_val  = (k < last_k) && !stalled;
            if (sel == 0) en0 = en_val; else en1 = en_val;
            #1;
            if (sel == 0) begin
                sv = int'(v0); sd = int'(d0); sx = int'(x0); sw = int'(wrd0);
                sa_o = int'(a0); swr = int'(w0); sww = int'(ww0); sdn = int'(dn0);
            end else begin
                sv = int'(v1); sd = int'(d1); sx = int'(x1); sw = int'(wrd1);
                sa_o = int'(a1); swr = int'(w1); sww = int'(ww1); sdn = int'(dn1);
            end

            in_run = (k < n_issue + sl);
            m = stalled ? sa : ((k >= sa + sl) ? k - sl : k);
            t = m % T;
            j = (m / T) % I;
            c = m / (T * I);
            check("valid", sv, (in_run && !stalled) ? 1 : 0);
            check("addr_d", sd, in_run ? t * C + c : 0);
            check("addr_x", sx, in_run ? t * I + j : 0);
            check("addr_w_rd", sw, in_run ? c * I + j : 0);
            check("acc", sa_o, (in_run && t != 0) ? 1 : 0);

            q = k - D;
            e_wr = 0;
            e_ww = 0;
            if (q >= 0 && !((q >= sa) && (q < sa + sl))) begin
                mq = (q >= sa + sl) ? q - sl : q;
                if (mq < n_issue && (mq % T) == T - 1) begin
                    e_wr = 1;
                    e_ww = mq / T;
                end
            end
            check("wr", swr, e_wr);
            check("addr_w_wr", sww, e_ww);
            check("done", sdn, (k == n_issue + sl + D) ? 1 : 0);
            wr_cnt += swr;

            if (sel == 0 && sl == 0) begin
                if (k == 0)   check("k0_d", sd, 0);
                if (k == 6)   check("k6_d", sd, 48);
                if (k == 6)   check("k6_x", sx, 48);
                if (k == 6)   check("k6_acc", sa_o, 1);
                if (k == 9)   check("k9_wr", swr, 1);
                if (k == 450) check("k450_waddr", sww, 63);
                if (k == 451) check("k451_done", sdn, 1);
            end
            if (sel == 0 && sl == 5 && k == 5) begin
                check("stall_d", sd, 24);
                check("stall_valid", sv, 0);
            end
            if (sel == 0 && sl == 5 && k == 14) check("stall_wr14", swr, 1);
            if (sel == 1 && k == 7) check("p1_done7", sdn, 1);
        end
        check("wr_count", wr_cnt, C * I);
        if (sel == 0) en0 = 1'b0; else en1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en0 = 1'b0;
        en1 = 1'b0;
        #2;
        check("rst_valid", int'(v0), 0);
        check("rst_wr", int'(w0), 0);
        check("rst_done", int'(dn0), 0);
        check("rst_addr_d", int'(d0), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_seq(0, 7, 8, 8, 3, 0, 0);
        @(posedge clk);
        #2;
        check("idle_valid", int'(v0), 0);

        run_seq(0, 7, 8, 8, 3, 3, 5);

        // Start a run, then reset asynchronously while weight 0's write is queued.
        en0 = 1'b1;
        for (int k = 0; k <= 8; k++) @(posedge clk);
        #2;
        cur_k = 8;
        rst = 1'b1;
        #1;
        check("mrst_d", int'(d0), 0);
        check("mrst_x", int'(x0), 0);
        check("mrst_wrd", int'(wrd0), 0);
        check("mrst_valid", int'(v0), 0);
        check("mrst_acc", int'(a0), 0);
        check("mrst_wr", int'(w0), 0);
        check("mrst_waddr", int'(ww0), 0);
        check("mrst_done", int'(dn0), 0);
        @(posedge clk);
        #1;
        en0 = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #2;
            cur_k = k;
            check("post_rst_wr", int'(w0), 0);
            check("post_rst_done", int'(dn0), 0);
            check("post_rst_valid", int'(v0), 0);
        end

        run_seq(0, 7, 8, 8, 3, 0, 0);
        run_seq(1, 1, 2, 3, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
